// File: rtl/zone_sequence_timer.sv
// Irrigation zone sequencer: runs each enabled zone for its BCD preset minutes,
// separated by a valve-off gap, with abort and sticky error handling.
module zone_sequence_timer #(
  parameter int  NUM_ZONES   = 4,
  parameter int  GAP_SECONDS = 2,
  localparam int ZW          = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sec_tick,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   irrigation_on,
  input  logic                   conflicting_values,
  input  logic [NUM_ZONES-1:0]   zone_enable,
  input  logic [8*NUM_ZONES-1:0] preset_minutes,
  output logic [NUM_ZONES-1:0]   zone_valve,
  output logic [ZW-1:0]          zone_index,
  output logic [2:0]             minutes_d,
  output logic [3:0]             minutes_u,
  output logic [2:0]             seconds_d,
  output logic [3:0]             seconds_u,
  output logic                   busy,
  output logic                   seq_done,
  output logic                   error
);

  // Padded to a power of two so the zone index can address the latched copies.
  localparam int            NZP     = 1 << ZW;
  localparam int            IW      = ZW + 1;
  localparam logic [IW-1:0] END_IDX = IW'(NUM_ZONES);
  localparam logic [3:0]    GAP_M1  = 4'(GAP_SECONDS - 1);
  localparam bit            GAP_EN  = (GAP_SECONDS > 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_RUN    = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IW-1:0]      r_idx, w_idx_nxt;
  logic [13:0]        r_time, w_time_nxt;
  logic [3:0]         r_gap, w_gap_nxt;
  logic               r_err, w_err_nxt;
  logic [NZP-1:0]     r_en, w_en_nxt;
  logic [8*NZP-1:0]   r_pre, w_pre_nxt;

  logic               w_abort;
  logic               w_start_ok;
  logic [ZW-1:0]      w_cur;
  logic [7:0]         w_byte;
  logic [3:0]         w_tens;
  logic [3:0]         w_units;
  logic               w_bcd_ok;
  logic               w_nonzero;
  logic               w_last;
  logic [NZP-1:0]     w_onehot;

  // Time is packed {min_d[2:0], min_u[3:0], sec_d[2:0], sec_u[3:0]}; caller guarantees nonzero.
  function automatic logic [13:0] bcd_dec(input logic [13:0] t);
    logic [2:0] md;
    logic [3:0] mu;
    logic [2:0] sd;
    logic [3:0] su;
    {md, mu, sd, su} = t;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (sd != 3'd0) begin
        sd = sd - 3'd1;
      end else begin
        sd = 3'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          md = md - 3'd1;
        end
      end
    end
    return {md, mu, sd, su};
  endfunction

  assign w_abort    = stop | ~irrigation_on | conflicting_values;
  assign w_start_ok = start & ~w_abort;
  assign w_cur      = r_idx[ZW-1:0];
  assign w_byte     = r_pre[{w_cur, 3'b000} +: 8];
  assign w_tens     = w_byte[7:4];
  assign w_units    = w_byte[3:0];
  assign w_bcd_ok   = (w_tens <= 4'd5) && (w_units <= 4'd9);
  assign w_nonzero  = (w_byte != 8'h00);
  assign w_last     = (r_idx >= END_IDX);
  assign w_onehot   = {{(NZP-1){1'b0}}, 1'b1} << w_cur;

  // Next-state and datapath; abort outranks every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_time_nxt  = r_time;
    w_gap_nxt   = r_gap;
    w_err_nxt   = r_err;
    w_en_nxt    = r_en;
    w_pre_nxt   = r_pre;
    if ((r_state != S_IDLE) && w_abort) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_time_nxt  = 14'd0;
      w_gap_nxt   = 4'd0;
      w_err_nxt   = r_err | conflicting_values;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            w_state_nxt                       = S_SELECT;
            w_en_nxt                          = '0;
            w_en_nxt[NUM_ZONES-1:0]           = zone_enable;
            w_pre_nxt                         = '0;
            w_pre_nxt[8*NUM_ZONES-1:0]        = preset_minutes;
            w_err_nxt                         = 1'b0;
            w_idx_nxt                         = '0;
            w_time_nxt                        = 14'd0;
            w_gap_nxt                         = 4'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_SELECT: begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else if (r_en[w_cur] && w_bcd_ok && w_nonzero) begin
            w_state_nxt = S_RUN;
            w_time_nxt  = {w_tens[2:0], w_units, 7'd0};
          end else if (r_en[w_cur] && !w_bcd_ok) begin
            w_err_nxt = 1'b1;
            w_idx_nxt = r_idx + IW'(1);
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
        S_RUN: begin
          // 00:00 is held for one cycle so the zero is visible before leaving.
          if (r_time == 14'd0) begin
            if (GAP_EN) begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = 4'd0;
            end else begin
              w_state_nxt = S_SELECT;
              w_idx_nxt   = r_idx + IW'(1);
            end
          end else if (sec_tick) begin
            w_time_nxt = bcd_dec(r_time);
          end else begin
            w_time_nxt = r_time;
          end
        end
        S_GAP: begin
          w_time_nxt = 14'd0;
          if (sec_tick) begin
            if (r_gap == GAP_M1) begin
              w_state_nxt = S_SELECT;
              w_idx_nxt   = r_idx + IW'(1);
              w_gap_nxt   = 4'd0;
            end else begin
              w_gap_nxt = r_gap + 4'd1;
            end
          end else begin
            w_gap_nxt = r_gap;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_time_nxt  = 14'd0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_time_nxt  = 14'd0;
          w_gap_nxt   = 4'd0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_time  <= 14'd0;
      r_gap   <= 4'd0;
      r_err   <= 1'b0;
      r_en    <= '0;
      r_pre   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_time  <= w_time_nxt;
      r_gap   <= w_gap_nxt;
      r_err   <= w_err_nxt;
      r_en    <= w_en_nxt;
      r_pre   <= w_pre_nxt;
    end
  end

  assign zone_valve = (r_state == S_RUN) ? w_onehot[NUM_ZONES-1:0] : '0;
  assign zone_index = r_idx[ZW-1:0];
  assign minutes_d  = r_time[13:11];
  assign minutes_u  = r_time[10:7];
  assign seconds_d  = r_time[6:4];
  assign seconds_u  = r_time[3:0];
  assign busy       = (r_state != S_IDLE);
  assign seq_done   = (r_state == S_DONE);
  assign error      = r_err;

endmodule
